// File: rtl/mesm6_ifetch_queue_if.sv
// Bundle of the instruction bus, the opcode delivery handshake and the
// flush request that connect the prefetch queue to the rest of the core.
interface mesm6_ifetch_queue_if #(
    parameter int ADDR_W = 15,
    parameter int WORD_W = 48
);
    logic                  flush;
    logic [ADDR_W:0]       flush_pc;

    logic                  ibus_fetch;
    logic [ADDR_W-1:0]     ibus_addr;
    logic [WORD_W-1:0]     ibus_input;
    logic                  ibus_done;

    logic                  op_valid;
    logic [WORD_W/2-1:0]   op_data;
    logic [ADDR_W:0]       op_pc;
    logic                  op_ready;

    // The prefetch queue itself: masters the ibus, sources opcodes.
    modport master (
        input  flush, flush_pc, ibus_input, ibus_done, op_ready,
        output ibus_fetch, ibus_addr, op_valid, op_data, op_pc
    );

    // Surrounding core: memory side of the ibus plus the sequencer.
    modport slave (
        output flush, flush_pc, ibus_input, ibus_done, op_ready,
        input  ibus_fetch, ibus_addr, op_valid, op_data, op_pc
    );
endinterface

// File: rtl/mesm6_ifetch_queue.sv
// MESM-6 instruction prefetch queue: fetches instruction words ahead of
// execution into a DEPTH-word ring buffer and hands out 24-bit half-word
// opcodes (left half first) together with their half-word PC.
module mesm6_ifetch_queue #(
    parameter int              ADDR_W   = 15,
    parameter int              WORD_W   = 48,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    mesm6_ifetch_queue_if.master bus
);
    localparam int HALF  = WORD_W / 2;
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W:0]    DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]    CNT_ONE = 1;
    localparam logic [PTR_W-1:0]  PTR_ONE = 1;
    localparam logic [ADDR_W-1:0] FA_ONE  = 1;
    localparam logic [ADDR_W:0]   PC_ONE  = 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;
    logic [ADDR_W-1:0] fa;
    logic [ADDR_W-1:0] addr_q;
    logic              pending;
    logic              discard;
    logic [ADDR_W:0]   op_pc_q;

    logic [WORD_W-1:0] head;
    logic              consume;
    logic              do_pop;
    logic              complete;
    logic              do_write;
    logic              issue;

    // Decode this cycle's events; flush overrides both consume and write.
    always_comb begin
        head     = mem[rd_ptr];
        consume  = (count != '0) && bus.op_ready && !bus.flush;
        do_pop   = consume && op_pc_q[0];
        complete = pending && bus.ibus_done;
        do_write = complete && !discard && !bus.flush;
        issue    = !pending && (count < DEPTH_C) && !bus.flush;
    end

    assign bus.op_valid   = (count != '0);
    assign bus.op_data    = op_pc_q[0] ? head[HALF-1:0] : head[WORD_W-1:HALF];
    assign bus.op_pc      = op_pc_q;
    assign bus.ibus_fetch = pending;
    assign bus.ibus_addr  = addr_q;

    // Word storage; only accepted (non-discarded) responses are written.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= bus.ibus_input;
        end
    end

    // Ring pointers and occupancy; a pop and a write together leave count alone.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)   rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_write, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Fetch engine: one outstanding request, address held until the bus answers,
    // and a discard flag that swallows the response of a fetch overtaken by flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            fa      <= RESET_PC[ADDR_W:1];
            addr_q  <= RESET_PC[ADDR_W:1];
            pending <= 1'b0;
            discard <= 1'b0;
        end else begin
            if (bus.flush) begin
                fa <= bus.flush_pc[ADDR_W:1];
            end else if (do_write) begin
                fa <= fa + FA_ONE;
            end

            if (issue) begin
                pending <= 1'b1;
                addr_q  <= fa;
            end else if (complete) begin
                pending <= 1'b0;
            end

            if (bus.flush) begin
                discard <= pending && !bus.ibus_done;
            end else if (complete) begin
                discard <= 1'b0;
            end
        end
    end

    // Half-word PC of the opcode currently presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_pc_q <= RESET_PC;
        end else if (bus.flush) begin
            op_pc_q <= bus.flush_pc;
        end else if (consume) begin
            op_pc_q <= op_pc_q + PC_ONE;
        end
    end
endmodule

// File: tb/tb_mesm6_ifetch_queue.sv
// Self-checking bench for mesm6_ifetch_queue: a bus responder with random
// wait states, a scoreboard fed with the expected opcode stream whenever the
// PC is (re)started, and directed scenarios followed by a random phase.
module tb_mesm6_ifetch_queue;
    localparam int              ADDR_W   = 15;
    localparam int              WORD_W   = 48;
    localparam int              DEPTH    = 4;
    localparam logic [ADDR_W:0] RESET_PC = '0;

    typedef struct packed {
        logic [15:0] pc;
        logic [23:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    mesm6_ifetch_queue_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

    mesm6_ifetch_queue #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pops   = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [14:0] addr_log[$];

    int          bus_wait_max = 0;
    int          fixed_wait   = -1;
    int          slow_addr    = -1;
    int          slow_wait    = 3;
    int          busy         = 0;
    int          wait_left    = 0;
    logic [14:0] held_addr;

    // Memory image: word n holds {n, ~n} in its two 24-bit halves.
    function automatic logic [47:0] mem_word(input logic [14:0] a);
        logic [23:0] hi;
        hi = {9'd0, a};
        return {hi, ~hi};
    endfunction

    // Opcode at a half-word PC: even PC is the left half, odd the right half.
    function automatic logic [23:0] exp_half(input logic [15:0] pc);
        logic [47:0] w;
        w = mem_word(pc[15:1]);
        return pc[0] ? w[23:0] : w[47:24];
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic push_stream(input logic [15:0] start_pc, input int n);
        exp_t        e;
        logic [15:0] pc;
        pc = start_pc;
        for (int i = 0; i < n; i++) begin
            e.pc   = pc;
            e.data = exp_half(pc);
            exp_q.push_back(e);
            pc = pc + 16'd1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        bus.flush = 1'b0;
        tick();
        tick();
        exp_q.delete();
        push_stream(RESET_PC, 512);
        addr_log.delete();
        reset = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [15:0] pc);
        bus.flush    = 1'b1;
        bus.flush_pc = pc;
        exp_q.delete();
        push_stream(pc, 512);
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic wait_until_fetch(input logic [14:0] a, input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (bus.ibus_fetch && bus.ibus_addr == a) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL wait_fetch: no fetch of 0x%0h within %0d cycles, required one", a, bound);
        end
    endtask

    // Bus responder: answers each request after a chosen number of wait cycles
    // and checks the address is held for the whole transaction.
    always @(posedge clk) begin
        #1;
        if (reset || !bus.ibus_fetch) begin
            busy          = 0;
            bus.ibus_done = 1'b0;
        end else begin
            if (busy == 0) begin
                busy      = 1;
                held_addr = bus.ibus_addr;
                addr_log.push_back(bus.ibus_addr);
                if (fixed_wait >= 0)
                    wait_left = fixed_wait;
                else if (int'(bus.ibus_addr) == slow_addr)
                    wait_left = slow_wait;
                else
                    wait_left = int'($urandom_range(0, bus_wait_max));
            end else begin
                check_output("ibus_addr_stable", bus.ibus_addr, held_addr);
            end
            if (wait_left == 0) begin
                bus.ibus_done  = 1'b1;
                bus.ibus_input = mem_word(held_addr);
                busy           = 0;
            end else begin
                bus.ibus_done = 1'b0;
                wait_left--;
            end
        end
    end

    // Monitor: every accepted opcode is compared with the scoreboard head.
    always @(negedge clk) begin
        if (!reset && !bus.flush && bus.op_valid && bus.op_ready) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL scoreboard_empty: opcode pc 0x%0h delivered, none expected", bus.op_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("op_pc", bus.op_pc, mon_e.pc);
                check_output("op_data", bus.op_data, mon_e.data);
            end
        end
    end

    // Watchdog so a stuck design can never hang the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int base;
        int pops_before;
        bit found;

        reset          = 1'b1;
        bus.flush      = 1'b0;
        bus.flush_pc   = '0;
        bus.op_ready   = 1'b0;
        bus.ibus_done  = 1'b0;
        bus.ibus_input = '0;
        @(posedge clk);
        #2;

        // Sequential stream from reset, zero-wait bus, consumer always ready.
        $display("[TB] reset and sequential stream");
        bus.op_ready = 1'b1;
        apply_reset();
        check_output("reset_op_valid", bus.op_valid, 1'b0);
        check_output("reset_ibus_fetch", bus.ibus_fetch, 1'b0);
        check_output("reset_op_pc", bus.op_pc, RESET_PC);
        tick();
        check_output("first_fetch", bus.ibus_fetch, 1'b1);
        check_output("first_addr", bus.ibus_addr, 15'd0);
        repeat (40) tick();
        check_output("seq_fetch_count_ge4", addr_log.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            check_output("seq_addr", addr_log[i], i);
        check_output("seq_pops_ge20", n_pops >= 20, 1'b1);

        // Stalled consumer: queue fills with exactly DEPTH words.
        $display("[TB] stalled consumer");
        bus.op_ready = 1'b0;
        apply_reset();
        repeat (30) tick();
        check_output("full_fetch_count", addr_log.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < addr_log.size(); i++)
            check_output("full_addr", addr_log[i], i);
        check_output("full_ibus_fetch", bus.ibus_fetch, 1'b0);
        check_output("full_op_valid", bus.op_valid, 1'b1);
        bus.op_ready = 1'b1;
        wait_until_fetch(15'd4, 10);
        check_output("resume_fetch_count", addr_log.size(), DEPTH + 1);

        // Wrap-around flush with latency checks on an idle full queue.
        $display("[TB] wrap flush and latency");
        bus.op_ready = 1'b0;
        repeat (20) tick();
        base = addr_log.size();
        apply_stimulus(16'hFFFE);
        check_output("lat_no_fetch_in_flush", bus.ibus_fetch, 1'b0);
        check_output("lat_queue_cleared", bus.op_valid, 1'b0);
        tick();
        check_output("lat_fetch_rise", bus.ibus_fetch, 1'b1);
        check_output("lat_fetch_addr", bus.ibus_addr, 15'h7FFF);
        tick();
        check_output("lat_op_valid", bus.op_valid, 1'b1);
        check_output("lat_op_pc", bus.op_pc, 16'hFFFE);
        check_output("lat_op_data", bus.op_data, exp_half(16'hFFFE));
        bus.op_ready = 1'b1;
        repeat (10) tick();
        check_output("wrap_fetch_count_ge2", addr_log.size() >= base + 2, 1'b1);
        if (addr_log.size() >= base + 2) begin
            check_output("wrap_addr0", addr_log[base], 15'h7FFF);
            check_output("wrap_addr1", addr_log[base + 1], 15'h0000);
        end

        // Flush while a slow fetch of word 2 is outstanding.
        $display("[TB] flush during outstanding fetch");
        bus.op_ready = 1'b1;
        slow_addr    = 2;
        slow_wait    = 3;
        apply_reset();
        wait_until_fetch(15'd2, 20);
        apply_stimulus(16'h0015);
        check_output("held_fetch", bus.ibus_fetch, 1'b1);
        check_output("held_addr", bus.ibus_addr, 15'd2);
        slow_addr = -1;
        base = addr_log.size();
        wait_until_fetch(15'h000A, 20);
        check_output("restart_single_fetch", addr_log.size(), base + 1);
        repeat (20) tick();

        // Pop of a word and completion of a fetch in the same cycle.
        $display("[TB] simultaneous pop and completion");
        bus.op_ready = 1'b0;
        apply_reset();
        repeat (20) tick();
        slow_addr    = 4;
        slow_wait    = 2;
        bus.op_ready = 1'b1;
        repeat (3) tick();
        bus.op_ready = 1'b0;
        check_output("pre_pop_pc", bus.op_pc, 16'd3);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.ibus_done) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_output("done_seen", found, 1'b1);
        if (found) begin
            bus.op_ready = 1'b1;
            tick();
            bus.op_ready = 1'b0;
        end
        slow_addr = -1;
        base = addr_log.size();
        repeat (20) tick();
        check_output("refill_fetches", addr_log.size() - base, 1);
        check_output("refill_idle", bus.ibus_fetch, 1'b0);
        check_output("post_pop_pc", bus.op_pc, 16'd4);
        bus.op_ready = 1'b1;
        repeat (30) tick();

        // Reset in the middle of a fetch with words queued.
        $display("[TB] reset mid-fetch");
        bus.op_ready = 1'b0;
        fixed_wait   = 4;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.ibus_fetch && !bus.ibus_done && bus.op_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_output("midfetch_precondition", found, 1'b1);
        reset = 1'b1;
        exp_q.delete();
        tick();
        check_output("midreset_op_valid", bus.op_valid, 1'b0);
        check_output("midreset_ibus_fetch", bus.ibus_fetch, 1'b0);
        check_output("midreset_op_pc", bus.op_pc, RESET_PC);
        fixed_wait = -1;
        tick();
        push_stream(RESET_PC, 512);
        addr_log.delete();
        reset = 1'b0;
        bus.op_ready = 1'b1;
        repeat (20) tick();

        // Random traffic: consumer stalls, bus wait states, flushes, resets.
        $display("[TB] random phase");
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) bus_wait_max = int'($urandom_range(0, 3));
            bus.op_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 999) == 0)
                apply_reset();
            else if ($urandom_range(0, 49) == 0 || c % 200 == 199)
                apply_stimulus(16'($urandom_range(0, 65535)));
            else
                tick();
        end

        bus_wait_max = 0;
        bus.op_ready = 1'b1;
        pops_before  = n_pops;
        repeat (20) tick();
        check_output("drain_progress", (n_pops - pops_before) >= 10, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
